// File: rtl/xcvr_refclk_mon.sv
// Reference-clock frequency monitor: per-channel edge counting over a fixed window, health
// tracking and active-channel selection. Define XCVR_REFCLK_MON_AUTO_FAILOVER_EN for autonomous failover.
module xcvr_refclk_mon #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned WINDOW   = 1024,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned MIN_CNT  = 480,
    parameter int unsigned MAX_CNT  = 544,
    parameter int unsigned GOOD_WIN = 3,
    parameter int unsigned HOLD_WIN = 2
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              MON_EN,
    input  logic [NUM_CH-1:0] REFCLK_TOG,
    input  logic [1:0]        SEL_REQ,
    output logic [NUM_CH-1:0] CH_OK,
    output logic [1:0]        SEL,
    output logic              SEL_VALID,
    output logic              SWITCH_PULSE,
    output logic              WIN_DONE,
    output logic [CNT_W-1:0]  CNT_LAST
);

    localparam int unsigned WIN_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [3:0]  GOOD_WIN4 = 4'(GOOD_WIN);
    localparam logic [2:0]  NUM_CH3   = 3'(NUM_CH);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);

    logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_CH-1:0] tog_edge;
    logic              run_q;
    logic              active, close;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [NUM_CH-1:0] ch_ok_q, ch_ok_d;
    logic [3:0]        ok_pad;
    logic [CNT_W-1:0]  final_cnt [4];
    logic [1:0]        sel_q, sel_d;
    logic              sel_valid_q, sel_valid_d;
    logic              switch_q;
    logic              win_done_q;
    logic [CNT_W-1:0]  cnt_last_q;
    logic              req_valid;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= REFCLK_TOG;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign tog_edge = sync2_q ^ sync3_q;

    // run_q holds off the window for one edge after reset so the window starts on that edge.
    assign active = MON_EN && run_q;
    assign close  = active && (win_cnt_q == WIN_LAST);

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (!active || close) begin
            win_cnt_d = '0;
        end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, cnt_now;
        logic [3:0]       streak_q, streak_d;
        logic             in_range, ok_next;

        always_comb begin
            // An edge in the close cycle still belongs to the closing window.
            cnt_now    = (edge_cnt_q == {CNT_W{1'b1}}) ? edge_cnt_q
                                                       : edge_cnt_q + CNT_W'(tog_edge[g]);
            in_range   = (cnt_now >= MIN_C) && (cnt_now <= MAX_C);
            edge_cnt_d = (!active || close) ? '0 : cnt_now;
            streak_d   = streak_q;
            ok_next    = ch_ok_q[g];
            if (!active) begin
                streak_d = '0;
                ok_next  = 1'b0;
            end else if (close) begin
                if (in_range) begin
                    if (streak_q < GOOD_WIN4) begin
                        streak_d = streak_q + 4'd1;
                    end
                    ok_next = (streak_d == GOOD_WIN4);
                end else begin
                    streak_d = '0;
                    ok_next  = 1'b0;
                end
            end
        end

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                edge_cnt_q <= '0;
                streak_q   <= '0;
            end else begin
                edge_cnt_q <= edge_cnt_d;
                streak_q   <= streak_d;
            end
        end

        assign final_cnt[g] = cnt_now;
        assign ch_ok_d[g]   = ok_next;
    end

    for (genvar g = NUM_CH; g < 4; g++) begin : g_pad
        assign final_cnt[g] = '0;
    end

    assign ok_pad    = 4'(ch_ok_d);
    assign req_valid = ({1'b0, SEL_REQ} < NUM_CH3);

`ifdef XCVR_REFCLK_MON_AUTO_FAILOVER_EN
    typedef enum logic [1:0] {StNone, StActive, StHold} sel_state_e;

    localparam sel_state_e StAfterSwitch = (HOLD_WIN == 0) ? StActive : StHold;
    localparam logic [3:0] HOLD_WIN4     = 4'(HOLD_WIN);

    sel_state_e state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] pick, alt;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [2:0] lowest_ok(input logic [3:0] mask);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        pick    = lowest_ok(ok_pad);
        alt     = lowest_ok(ok_pad & ~(4'b0001 << sel_q));
        if (!active) begin
            state_d = StNone;
            hold_d  = '0;
        end else if (close) begin
            case (state_q)
                StNone: begin
                    if (|ok_pad) begin
                        sel_d   = (req_valid && ok_pad[SEL_REQ]) ? SEL_REQ : pick[1:0];
                        state_d = StAfterSwitch;
                        hold_d  = '0;
                    end
                end
                StActive: begin
                    if (!ok_pad[sel_q]) begin
                        if (alt[2]) begin
                            sel_d   = alt[1:0];
                            state_d = StAfterSwitch;
                            hold_d  = '0;
                        end else begin
                            state_d = StNone;
                        end
                    end else if (req_valid && (SEL_REQ != sel_q) && ok_pad[SEL_REQ]) begin
                        sel_d   = SEL_REQ;
                        state_d = StAfterSwitch;
                        hold_d  = '0;
                    end
                end
                StHold: begin
                    if (!ok_pad[sel_q]) begin
                        state_d = StNone;
                    end else if ((hold_q + 4'd1) >= HOLD_WIN4) begin
                        state_d = StActive;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                default: state_d = StNone;
            endcase
        end
    end

    assign sel_valid_d = (state_d != StNone);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= StNone;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end
`else
    always_comb begin
        sel_d = sel_q;
        if (close && req_valid) begin
            sel_d = SEL_REQ;
        end
    end

    assign sel_valid_d = ok_pad[sel_d];
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            run_q       <= 1'b0;
            win_cnt_q   <= '0;
            ch_ok_q     <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            switch_q    <= 1'b0;
            win_done_q  <= 1'b0;
            cnt_last_q  <= '0;
        end else begin
            run_q       <= 1'b1;
            win_cnt_q   <= win_cnt_d;
            ch_ok_q     <= ch_ok_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            switch_q    <= (sel_d != sel_q);
            win_done_q  <= close;
            if (close) begin
                cnt_last_q <= final_cnt[sel_d];
            end
        end
    end

    assign CH_OK        = ch_ok_q;
    assign SEL          = sel_q;
    assign SEL_VALID    = sel_valid_q;
    assign SWITCH_PULSE = switch_q;
    assign WIN_DONE     = win_done_q;
    assign CNT_LAST     = cnt_last_q;

endmodule

// File: doc/xcvr_refclk_mon.md
XCVR_REFCLK_MON -- requirements
Module: xcvr_refclk_mon

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of monitored reference-clock channels (legal 1..4).
REQ-002 SHALL have parameter WINDOW, default 1024, meaning measurement window length in CLK cycles (legal >= 16).
REQ-003 SHALL have parameter CNT_W, default 12, meaning edge-counter and CNT_LAST width.
REQ-004 SHALL have parameters MIN_CNT, default 480, and MAX_CNT, default 544, meaning the inclusive legal edge count per window.
REQ-005 SHALL have parameter GOOD_WIN, default 3, meaning consecutive in-range windows needed to declare a channel OK (legal 1..15).
REQ-006 SHALL have parameter HOLD_WIN, default 2, meaning windows after a switch during which no further switch occurs (legal 0..15).
REQ-007 SHALL have port CLK  input  1  single system clock; all logic is on its rising edge.
REQ-008 SHALL have port RESETN  input  1  asynchronous active-low reset.
REQ-009 SHALL have port MON_EN  input  1  monitor enable.
REQ-010 SHALL have port REFCLK_TOG  input  NUM_CH  per-channel divided-refclk toggle signal, asynchronous to CLK.
REQ-011 SHALL have port SEL_REQ  input  2  requested channel index.
REQ-012 SHALL have port CH_OK  output  NUM_CH  per-channel health.
REQ-013 SHALL have port SEL  output  2  active channel index.
REQ-014 SHALL have port SEL_VALID  output  1  SEL points at an OK channel.
REQ-015 SHALL have port SWITCH_PULSE  output  1  one-cycle pulse on every SEL change.
REQ-016 SHALL have port WIN_DONE  output  1  one-cycle pulse at each window close.
REQ-017 SHALL have port CNT_LAST  output  CNT_W  edge count of the selected channel from the last closed window.

Function
REQ-018 SHALL synchronise each REFCLK_TOG bit through 2 flops, then detect both edges with a third flop.
REQ-019 SHALL run a window counter 0..WINDOW-1 while MON_EN=1; the cycle at WINDOW-1 is the close cycle, with WIN_DONE=1 registered one cycle later.
REQ-020 SHALL count, per channel, detected edges saturating at 2^CNT_W-1; an edge in the close cycle counts toward the closing window; counters restart at 0 next cycle.
REQ-021 SHALL, at close, classify each channel good if MIN_CNT <= count <= MAX_CNT, otherwise bad.
REQ-022 SHALL, per channel, keep a good-streak counter: bad clears streak and drops CH_OK in the same update; good increments streak (saturating at GOOD_WIN) and sets CH_OK when streak reaches GOOD_WIN.
REQ-023 SHALL update CH_OK, CNT_LAST and selection together, in the cycle WIN_DONE asserts.
REQ-024 SHALL implement selection FSM states NONE, ACTIVE, HOLD:
 - NONE (SEL_VALID=0): on any CH_OK, select SEL_REQ if OK, else lowest-index OK channel; go HOLD.
 - ACTIVE: if CH_OK[SEL] falls, switch per failover rule (REQ-031); if SEL_REQ!=SEL and CH_OK[SEL_REQ]=1, switch to SEL_REQ; go HOLD.
 - HOLD: count HOLD_WIN windows, ignoring SEL_REQ; if CH_OK[SEL] falls, go NONE; at count end go ACTIVE (HOLD_WIN=0: straight to ACTIVE).
REQ-025 SHALL pulse SWITCH_PULSE exactly once per SEL value change, never when SEL is unchanged.
REQ-026 SHALL treat SEL_REQ >= NUM_CH as no request.
REQ-027 SHALL, when MON_EN=0, hold the window counter at 0, clear edge counters, streaks and CH_OK, go NONE and hold SEL; on MON_EN rising, start a full window.

Reset
REQ-028 SHALL, on RESETN low, asynchronously clear all flops: CH_OK=0, SEL=0, SEL_VALID=0, SWITCH_PULSE=0, WIN_DONE=0, CNT_LAST=0, FSM=NONE.
REQ-029 SHALL resume counting from window start on the first CLK edge after RESETN deasserts; reset mid-window discards the partial window.

Configuration
REQ-030 SHALL provide macro XCVR_REFCLK_MON_AUTO_FAILOVER_EN.
REQ-031 SHALL, with the macro defined, on loss of the selected channel switch to the lowest-index other OK channel, or go NONE if none.
REQ-032 SHALL, without the macro, never switch autonomously: SEL follows SEL_REQ (valid index) at each close, SEL_VALID=CH_OK[SEL], FSM and HOLD logic absent, SWITCH_PULSE still per SEL change.

Verification (NUM_CH=2, WINDOW=100, MIN_CNT=45, MAX_CNT=55, GOOD_WIN=3, HOLD_WIN=2)
REQ-033 SHALL cover: both channels toggling every 2 CLK -> CNT_LAST=50, CH_OK=2'b11 and SEL_VALID=1, SEL=0 after 3rd WIN_DONE.
REQ-034 SHALL cover: ch0 stops toggling after lock -> at next close CH_OK[0]=0; with macro SEL=1 plus one SWITCH_PULSE; without macro SEL_VALID=0, SEL=0.
REQ-035 SHALL cover: ch1 toggles every 1 CLK (100 edges) -> CH_OK[1] never asserts; SEL_REQ=1 ignored.
REQ-036 SHALL cover: SEL_REQ 0->1 one cycle after a switch (macro on) -> SEL changes only at the 3rd close after the switch (HOLD expires at 2nd, ACTIVE switches at 3rd).
REQ-037 SHALL cover: RESETN low at window cycle 60 -> all outputs 0 within the cycle; after release, first WIN_DONE 101 cycles later.
REQ-038 SHALL cover: MON_EN low for 10 cycles -> CH_OK=0, SEL_VALID=0, no WIN_DONE; relock after 3 windows.
